// File: rtl/accum_seq.sv
// accum_seq: sequences a byte stream through an external 8-bit adder.
// Accumulates NUM_OPS operands and reports the sum plus a sticky overflow flag.
//
// Ports:
//   clk, n_rst          clock (rising edge), async active-low reset
//   start, clear        begin request (IDLE only), synchronous abort
//   data_in/valid/ready operand handshake from upstream
//   add_a/b/cin         drive the combinational adder
//   add_sum/overflow    adder result and carry-out
//   result/result_ovf   last completed sum and its sticky overflow
//   done, busy          completion pulse, ACCUM-state indicator
module accum_seq #(
  parameter int NUM_OPS   = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_overflow,
  output logic [7:0] result,
  output logic       result_ovf,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(NUM_OPS - 1);

  state_t               state, state_n;
  logic [7:0]           acc, acc_n;
  logic [CNT_WIDTH-1:0] count, count_n;
  logic                 sticky, sticky_n;
  logic [7:0]           result_n;
  logic                 result_ovf_n;

  assign add_a      = acc;
  assign add_b      = data_in;
  assign add_cin    = 1'b0;
  assign busy       = (state == ACCUM);
  assign data_ready = (state == ACCUM);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      sticky     <= 1'b0;
      result     <= '0;
      result_ovf <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      count      <= count_n;
      sticky     <= sticky_n;
      result     <= result_n;
      result_ovf <= result_ovf_n;
    end
  end

  always_comb begin
    state_n      = state;
    acc_n        = acc;
    count_n      = count;
    sticky_n     = sticky;
    result_n     = result;
    result_ovf_n = result_ovf;
    if (clear) begin
      // Abort wins over start and over a same-cycle accept.
      state_n  = IDLE;
      acc_n    = '0;
      count_n  = '0;
      sticky_n = 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            state_n  = ACCUM;
            acc_n    = '0;
            count_n  = '0;
            sticky_n = 1'b0;
          end
        end
        (state == ACCUM): begin
          if (data_valid) begin
            acc_n    = add_sum;
            sticky_n = sticky | add_overflow;
            count_n  = count + 1'b1;
            if (count == LAST) begin
              state_n      = DONE;
              result_n     = add_sum;
              result_ovf_n = sticky | add_overflow;
            end
          end
        end
        (state == DONE): begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_seq.sv
// tb_accum_seq: directed plus randomized checks of accum_seq.
// Expected sums come from plain integer totals of the operand list.
module tb_accum_seq;

  localparam int N = 4;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       clear;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_overflow;
  logic [7:0] result;
  logic       result_ovf;
  logic       done;
  logic       busy;

  logic [8:0] wide_sum;
  logic [7:0] ops[$];
  int         tests;
  int         fails;
  int         done_cnt;

  accum_seq #(
    .NUM_OPS(N),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .clear(clear),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .add_a(add_a),
    .add_b(add_b),
    .add_cin(add_cin),
    .add_sum(add_sum),
    .add_overflow(add_overflow),
    .result(result),
    .result_ovf(result_ovf),
    .done(done),
    .busy(busy)
  );

  // Downstream 8-bit adder.
  assign wide_sum = {1'b0, add_a} + {1'b0, add_b}
                  + {8'd0, add_cin};
  assign add_sum      = wide_sum[7:0];
  assign add_overflow = wide_sum[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full accumulation of the ops queue with stall
  // cycles before each beat.
  task automatic run(input string tag, input int stall);
    int total;
    int d0;
    total = 0;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ":busy"}, 32'(busy), 32'd1);
    chk({tag, ":ready"}, 32'(data_ready), 32'd1);
    foreach (ops[i]) begin
      for (int s = 0; s < stall; s++) begin
        data_valid = 1'b0;
        data_in = 8'($urandom);
        step();
        chk({tag, ":hold"}, 32'(add_a), 32'(total % 256));
        chk({tag, ":hbusy"}, 32'(busy), 32'd1);
      end
      data_in = ops[i];
      data_valid = 1'b1;
      chk({tag, ":add_a"}, 32'(add_a), 32'(total % 256));
      step();
      total += int'(ops[i]);
    end
    data_valid = 1'b0;
    chk({tag, ":done"}, 32'(done), 32'd1);
    chk({tag, ":result"}, 32'(result), 32'(total % 256));
    chk({tag, ":ovf"}, 32'(result_ovf), 32'(total > 255));
    chk({tag, ":dbusy"}, 32'(busy), 32'd0);
    chk({tag, ":dready"}, 32'(data_ready), 32'd0);
    step();
    chk({tag, ":done0"}, 32'(done), 32'd0);
    chk({tag, ":held"}, 32'(result), 32'(total % 256));
    chk({tag, ":pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic [7:0] prev;
    int d0;
    tests = 0;
    fails = 0;
    n_rst = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    data_in = 8'h00;
    data_valid = 1'b0;
    #3 n_rst = 1'b0;
    #6;
    chk("rst:result", 32'(result), 32'd0);
    chk("rst:ovf", 32'(result_ovf), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:ready", 32'(data_ready), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    step();

    // data_valid while idle is ignored
    data_in = 8'hAA;
    data_valid = 1'b1;
    repeat (3) step();
    chk("idle:busy", 32'(busy), 32'd0);
    chk("idle:ready", 32'(data_ready), 32'd0);
    chk("idle:add_a", 32'(add_a), 32'd0);
    chk("idle:done", 32'(done_cnt), 32'd0);
    data_valid = 1'b0;

    // clear beats start
    start = 1'b1;
    clear = 1'b1;
    step();
    start = 1'b0;
    clear = 1'b0;
    chk("clrstart:busy", 32'(busy), 32'd0);

    ops = '{8'h10, 8'h20, 8'h30, 8'h40};
    run("basic", 0);
    chk("basic:val", 32'(result), 32'hA0);

    ops = '{8'hF0, 8'h20, 8'h01, 8'h01};
    run("wrap", 0);
    chk("wrap:val", 32'(result), 32'h12);
    chk("wrap:flag", 32'(result_ovf), 32'd1);

    ops = '{8'h05, 8'h05, 8'h05, 8'h05};
    run("stall", 3);
    chk("stall:val", 32'(result), 32'h14);

    // abort mid-run with a simultaneous accept
    prev = result;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    data_in = 8'h33;
    data_valid = 1'b1;
    step();
    chk("abort:acc", 32'(add_a), 32'h33);
    clear = 1'b1;
    step();
    clear = 1'b0;
    data_valid = 1'b0;
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:ready", 32'(data_ready), 32'd0);
    chk("abort:acc0", 32'(add_a), 32'd0);
    chk("abort:result", 32'(result), 32'(prev));
    repeat (2) step();
    chk("abort:nodone", 32'(done_cnt - d0), 32'd0);
    ops = '{8'h01, 8'h01, 8'h01, 8'h01};
    run("after_abort", 0);
    chk("after_abort:val", 32'(result), 32'h04);

    // async reset between edges after two accepts
    start = 1'b1;
    step();
    start = 1'b0;
    data_valid = 1'b1;
    data_in = 8'h7F;
    step();
    data_in = 8'h90;
    step();
    data_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk("arst:result", 32'(result), 32'd0);
    chk("arst:ovf", 32'(result_ovf), 32'd0);
    chk("arst:busy", 32'(busy), 32'd0);
    chk("arst:ready", 32'(data_ready), 32'd0);
    chk("arst:add_a", 32'(add_a), 32'd0);
    chk("arst:done", 32'(done), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    step();
    ops = '{8'h02, 8'h03, 8'h04, 8'h05};
    run("post_rst", 0);
    chk("post_rst:val", 32'(result), 32'h0E);

    // randomized operands and stalls
    for (int r = 0; r < 8; r++) begin
      ops.delete();
      for (int k = 0; k < N; k++)
        ops.push_back(8'($urandom));
      run("rand", int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
